// File: rtl/cr_sysio_mtime_pkg.sv
// Shared constants and helpers for the SYSIO machine timer.
//   MTIME_W        : width of the machine timer (64)
//   HALF_W         : bus access width, one half of mtime (32)
//   PRESCALE_W_DEF : default prescaler width
//   wr_tgt_e       : decoded target of a bus write
//   wr_decode()    : maps write strobe + selects to a write target; lo wins
//                    when both selects are set
package cr_sysio_mtime_pkg;

  localparam int unsigned MTIME_W        = 64;
  localparam int unsigned HALF_W         = 32;
  localparam int unsigned PRESCALE_W_DEF = 8;

  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_LO   = 2'd1,
    WR_HI   = 2'd2
  } wr_tgt_e;

  function automatic wr_tgt_e wr_decode(input logic vld, input logic lo_sel,
                                        input logic hi_sel);
    wr_tgt_e t;
    t = WR_NONE;
    if (vld && lo_sel)      t = WR_LO;
    else if (vld && hi_sel) t = WR_HI;
    return t;
  endfunction

endpackage

// File: rtl/cr_sysio_mtime_if.sv
// Bus-side access port of the machine timer.
//   busif_mtime_write_vld : single-cycle write strobe
//   busif_mtime_lo_sel    : access targets MTIME[31:0]
//   busif_mtime_hi_sel    : write targets MTIME[63:32]
//   busif_mtime_read_vld  : read strobe (with lo_sel captures the hi shadow)
//   busif_mtime_wdata     : write data
// master = bus interface unit, slave = timer.
interface cr_sysio_mtime_if;
  import cr_sysio_mtime_pkg::*;

  logic              busif_mtime_write_vld;
  logic              busif_mtime_lo_sel;
  logic              busif_mtime_hi_sel;
  logic              busif_mtime_read_vld;
  logic [HALF_W-1:0] busif_mtime_wdata;

  modport master (
    output busif_mtime_write_vld, busif_mtime_lo_sel, busif_mtime_hi_sel,
           busif_mtime_read_vld, busif_mtime_wdata
  );

  modport slave (
    input busif_mtime_write_vld, busif_mtime_lo_sel, busif_mtime_hi_sel,
          busif_mtime_read_vld, busif_mtime_wdata
  );
endinterface

// File: rtl/cr_sysio_mtime_prescaler.sv
// Tick prescaler: one raw tick every div+1 active cycles.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : enable; low clears the counter
//   halt_i        : freeze counter without clearing
//   div_i         : divider value
//   raw_tick_o    : combinational raw tick for the current cycle
module cr_sysio_mtime_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  halt_i,
  input  logic [PRESCALE_W-1:0] div_i,
  output logic                  raw_tick_o
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  // >= so that lowering div below the running count ticks at once
  assign raw_tick_o = en_i & ~halt_i & (pcnt_q >= div_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (!en_i)           pcnt_d = '0;
    else if (!halt_i)    pcnt_d = raw_tick_o ? '0 : pcnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pcnt_q <= '0;
    else         pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/cr_sysio_mtime.sv
// Free-running 64-bit machine timer feeding the CLINT.
//   clint_clk, cpurst_b : clock, async active-low reset
//   sysio_mtime_en      : counting enable
//   sysio_mtime_div     : prescaler divider (tick every div+1 cycles)
//   busif               : bus write/read port (cr_sysio_mtime_if.slave)
//   sysio_mtime_halt    : debug freeze, only with CR_SYSIO_MTIME_HALT_EN
//   sysio_clint_mtime   : registered timer value
//   mtime_hi_shadow     : MTIME[63:32] captured on a lo read
//   mtime_tick          : registered pulse when mtime incremented
// Define CR_SYSIO_MTIME_HALT_EN to add the halt port.
module cr_sysio_mtime
  import cr_sysio_mtime_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clint_clk,
  input  logic                  cpurst_b,
  input  logic                  sysio_mtime_en,
  input  logic [PRESCALE_W-1:0] sysio_mtime_div,
  cr_sysio_mtime_if.slave       busif,
`ifdef CR_SYSIO_MTIME_HALT_EN
  input  logic                  sysio_mtime_halt,
`endif
  output logic [MTIME_W-1:0]    sysio_clint_mtime,
  output logic [HALF_W-1:0]     mtime_hi_shadow,
  output logic                  mtime_tick
);

  logic               halt;
  logic               raw_tick;
  logic               tick_apply;
  wr_tgt_e            wr_tgt;
  logic [MTIME_W-1:0] mtime_q, mtime_d;
  logic [HALF_W-1:0]  shadow_q, shadow_d;
  logic               tick_q;

`ifdef CR_SYSIO_MTIME_HALT_EN
  assign halt = sysio_mtime_halt;
`else
  assign halt = 1'b0;
`endif

  cr_sysio_mtime_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i      (clint_clk),
    .rst_ni     (cpurst_b),
    .en_i       (sysio_mtime_en),
    .halt_i     (halt),
    .div_i      (sysio_mtime_div),
    .raw_tick_o (raw_tick)
  );

  assign wr_tgt = wr_decode(busif.busif_mtime_write_vld, busif.busif_mtime_lo_sel,
                            busif.busif_mtime_hi_sel);

  // A bus write to either half swallows a coincident tick
  assign tick_apply = raw_tick & (wr_tgt == WR_NONE);

  always_comb begin
    mtime_d = mtime_q;
    case (wr_tgt)
      WR_LO:   mtime_d = {mtime_q[MTIME_W-1:HALF_W], busif.busif_mtime_wdata};
      WR_HI:   mtime_d = {busif.busif_mtime_wdata, mtime_q[HALF_W-1:0]};
      default: if (tick_apply) mtime_d = mtime_q + MTIME_W'(1);
    endcase
  end

  // Shadow takes the pre-update hi half, matching the lo value on the bus
  always_comb begin
    shadow_d = shadow_q;
    if (busif.busif_mtime_read_vld && busif.busif_mtime_lo_sel)
      shadow_d = mtime_q[MTIME_W-1:HALF_W];
  end

  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      mtime_q  <= '0;
      shadow_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_apply;
    end
  end

  assign sysio_clint_mtime = mtime_q;
  assign mtime_hi_shadow   = shadow_q;
  assign mtime_tick        = tick_q;

endmodule

// File: tb/tb_cr_sysio_mtime.sv
module tb_cr_sysio_mtime;
  import cr_sysio_mtime_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  div;
  logic [63:0] mtime;
  logic [31:0] shadow;
  logic        tick;
`ifdef CR_SYSIO_MTIME_HALT_EN
  logic        halt;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  cr_sysio_mtime_if bus ();

  cr_sysio_mtime #(.PRESCALE_W(8)) dut (
    .clint_clk         (clk),
    .cpurst_b          (rst_n),
    .sysio_mtime_en    (en),
    .sysio_mtime_div   (div),
    .busif             (bus.slave),
`ifdef CR_SYSIO_MTIME_HALT_EN
    .sysio_mtime_halt  (halt),
`endif
    .sysio_clint_mtime (mtime),
    .mtime_hi_shadow   (shadow),
    .mtime_tick        (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.busif_mtime_write_vld = 1'b0;
    bus.busif_mtime_lo_sel    = 1'b0;
    bus.busif_mtime_hi_sel    = 1'b0;
    bus.busif_mtime_read_vld  = 1'b0;
    bus.busif_mtime_wdata     = '0;
  endtask

  task automatic wr(input logic lo, input logic hi, input logic [31:0] d);
    bus.busif_mtime_write_vld = 1'b1;
    bus.busif_mtime_lo_sel    = lo;
    bus.busif_mtime_hi_sel    = hi;
    bus.busif_mtime_wdata     = d;
    step();
    bus_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    div   = 8'd0;
`ifdef CR_SYSIO_MTIME_HALT_EN
    halt  = 1'b0;
`endif
    bus_idle();
    #12;
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_shadow", 64'(shadow), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);

    // div=0: tick every cycle
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    div = 8'd0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("div0_mtime", mtime, 64'(i));
      chk("div0_tick", 64'(tick), 64'd1);
    end
    en = 1'b0;
    step();
    chk("en0_hold", mtime, 64'd5);
    chk("en0_tick", 64'(tick), 64'd0);

    // async reset mid-cycle clears immediately
    rst_n = 1'b0;
    #2;
    chk("async_rst", mtime, 64'd0);
    rst_n = 1'b1;

    // div=3: tick every 4 cycles
    en = 1'b1;
    div = 8'd3;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("div3_tick", 64'(tick), (k % 4 == 0) ? 64'd1 : 64'd0);
      chk("div3_mtime", mtime, 64'(k / 4));
    end
    en = 1'b0;
    step();
    step();
    chk("div3_off_hold", mtime, 64'd3);
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("reen_tick", 64'(tick), (k == 4) ? 64'd1 : 64'd0);
    end
    chk("reen_mtime", mtime, 64'd4);

    // writes drop coincident ticks (div=0, en=1)
    div = 8'd0;
    wr(1'b0, 1'b1, 32'h0000_0000);
    chk("wr_hi_drop", mtime, 64'd4);
    chk("wr_hi_tick", 64'(tick), 64'd0);
    wr(1'b1, 1'b0, 32'hFFFF_FFFF);
    chk("wr_lo", mtime, 64'h0000_0000_FFFF_FFFF);
    en = 1'b1;
    step();
    chk("carry32", mtime, 64'h0000_0001_0000_0000);
    chk("carry32_tick", 64'(tick), 64'd1);

    // full wrap
    en = 1'b0;
    wr(1'b0, 1'b1, 32'hFFFF_FFFF);
    wr(1'b1, 1'b0, 32'hFFFF_FFFF);
    chk("all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    en = 1'b1;
    step();
    chk("wrap", mtime, 64'd0);
    chk("wrap_tick", 64'(tick), 64'd1);

    // lo write collides with tick
    wr(1'b1, 1'b0, 32'h0000_1234);
    chk("coll_mtime", mtime, 64'h0000_0000_0000_1234);
    chk("coll_tick", 64'(tick), 64'd0);

    // lo read with pending tick and carry into hi
    en = 1'b0;
    wr(1'b0, 1'b1, 32'h0000_0005);
    wr(1'b1, 1'b0, 32'hFFFF_FFFF);
    en = 1'b1;
    bus.busif_mtime_read_vld = 1'b1;
    bus.busif_mtime_lo_sel   = 1'b1;
    #1;
    chk("rd_lo_data", 64'(mtime[31:0]), 64'hFFFF_FFFF);
    step();
    bus_idle();
    chk("rd_shadow", 64'(shadow), 64'h5);
    chk("rd_mtime", mtime, 64'h0000_0006_0000_0000);

    // both selects: lo wins
    en = 1'b0;
    wr(1'b1, 1'b1, 32'h0000_00AB);
    chk("both_sel", mtime, 64'h0000_0006_0000_00AB);

    // lowering div below running count ticks next cycle
    en = 1'b1;
    div = 8'd5;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("div5_notick", 64'(tick), 64'd0);
    end
    div = 8'd1;
    step();
    chk("div_drop_tick", 64'(tick), 64'd1);
    chk("div_drop_mtime", mtime, 64'h0000_0006_0000_00AC);

`ifdef CR_SYSIO_MTIME_HALT_EN
    en = 1'b0;
    step();
    en = 1'b1;
    div = 8'd2;
    step();
    halt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("halt_hold", mtime, 64'h0000_0006_0000_00AC);
      chk("halt_tick", 64'(tick), 64'd0);
    end
    halt = 1'b0;
    step();
    chk("resume1_tick", 64'(tick), 64'd0);
    step();
    chk("resume2_tick", 64'(tick), 64'd1);
    chk("resume_mtime", mtime, 64'h0000_0006_0000_00AD);
    halt = 1'b1;
    wr(1'b1, 1'b0, 32'h0000_0077);
    chk("halt_wr", mtime, 64'h0000_0006_0000_0077);
    halt = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cr_sysio_mtime.md
# cr_sysio_mtime

Free-running 64-bit machine timer living in the SYSIO block. It produces the `sysio_clint_mtime` value consumed by the CLINT for MTIME reads and MTIMECMP comparison. It provides a programmable tick prescaler, 32-bit bus write access to each half of the counter, and a hi-half shadow register so software can read a coherent 64-bit value with two 32-bit accesses.

## Interface
Parameters:
- `PRESCALE_W`, 8, width of the prescaler divider and its counter.

Ports (clock and reset first):
- `clint_clk`  in  1  block clock; single clock domain.
- `cpurst_b`  in  1  reset, asynchronous, active-low.
- `sysio_mtime_en`  in  1  counting enable; level.
- `sysio_mtime_div`  in  PRESCALE_W  divider; one tick every div+1 enabled cycles.
- `busif_mtime_write_vld`  in  1  bus write strobe, single cycle.
- `busif_mtime_lo_sel`  in  1  write or read targets MTIME[31:0].
- `busif_mtime_hi_sel`  in  1  write targets MTIME[63:32].
- `busif_mtime_read_vld`  in  1  bus read strobe; together with lo_sel, captures the shadow.
- `busif_mtime_wdata`  in  32  write data.
- `sysio_mtime_halt`  in  1  debug freeze; present only with `CR_SYSIO_MTIME_HALT_EN`.
- `sysio_clint_mtime`  out  64  current timer value, registered.
- `mtime_hi_shadow`  out  32  MTIME[63:32] captured on a lo read.
- `mtime_tick`  out  1  registered one-cycle pulse when mtime increments.

## Operation
- Prescaler counter `pcnt` (PRESCALE_W bits), active when `sysio_mtime_en`=1 and the block is not halted.
- Raw tick when `pcnt >= sysio_mtime_div`. On a raw tick, `pcnt` is cleared; otherwise `pcnt` increments.
- The `>=` compare is required: reprogramming div below the current `pcnt` ticks on the next active cycle. It never waits for a wrap.
- `sysio_mtime_en`=0: `pcnt` is cleared and mtime holds. Counting restarts from a full period.
- Div=0: a tick occurs on every enabled cycle.
- mtime update priority, per cycle:
  - Write with lo_sel: mtime <= {mtime[63:32], wdata}.
  - Else write with hi_sel: mtime <= {wdata, mtime[31:0]}.
  - Else raw tick: mtime <= mtime + 1, with full 64-bit carry. All-ones wraps to 0; no sticky flag.
- When a bus write coincides with a raw tick, the tick is dropped. mtime does not increment that cycle and `mtime_tick` is not asserted. `pcnt` is still cleared.
- lo_sel and hi_sel both set in one write is illegal. The lo write is taken.
- Read with lo_sel loads `mtime_hi_shadow` with the mtime[63:32] value that is being returned on the bus that cycle, i.e. the pre-update value. Software reads lo, then reads the shadow.
- `mtime_tick` equals the registered raw tick that was actually applied.

## Timing
- Reset values: `sysio_clint_mtime`=0, `mtime_hi_shadow`=0, `mtime_tick`=0, `pcnt`=0.
- Write latency: a write at edge N is visible on `sysio_clint_mtime` after edge N+1.
- Tick latency: a raw tick in cycle N gives the incremented mtime and `mtime_tick`=1 after edge N+1.
- Enable or div change takes effect in the same cycle it is sampled.
- Asynchronous reset mid-count clears all state immediately. The first tick after release comes div+1 enabled cycles later.
- There is no handshake. Bus strobes are single-cycle and always accepted.

## Configuration
- `CR_SYSIO_MTIME_HALT_EN` defined:
  - The `sysio_mtime_halt` port exists.
  - halt=1 freezes both `pcnt` and mtime, with no clear.
  - Bus writes still apply during halt.
- Undefined: the port is absent and the block behaves as if halt=0.

## Structure
- Shared package holds:
  - the MTIME width constant (64);
  - the bus half width (32);
  - the default `PRESCALE_W`.
- Sub-module `cr_sysio_mtime_prescaler`:
  - contains `pcnt`, the compare and the halt/enable gating;
  - outputs the raw tick.
- The top level holds the 64-bit register, write muxing, shadow and tick register.

## Test plan
- Reset, en=1, div=0, run 5 cycles -> mtime=5; `mtime_tick` high for each of those 5 cycles.
- div=3, en=1, run 12 cycles -> mtime=3, with ticks 4 cycles apart. Drop en for 2 cycles, then re-enable -> the next tick arrives 4 cycles after re-enable.
- Write hi=0x0000_0000, lo=0xFFFF_FFFF, div=0 -> after 1 tick mtime=0x1_0000_0000. Write hi=lo=0xFFFF_FFFF -> after the next tick mtime=0 (wrap).
- Lo write of 0x1234 in the same cycle as a raw tick -> mtime[31:0]=0x1234, no increment, `mtime_tick`=0.
- mtime=0x5_FFFF_FFFF with a tick pending and a lo read in the same cycle -> lo returns 0xFFFF_FFFF and `mtime_hi_shadow`=0x5, while mtime becomes 0x6_0000_0000.
- With `CR_SYSIO_MTIME_HALT_EN`: div=2, halt=1 for 10 cycles -> mtime and `pcnt` unchanged. Release halt -> counting resumes from the held `pcnt`.
